ysyx_23060236_lsu_wmaster: RTL and testbench
============================================

Name: ysyx_23060236_lsu_wmaster

Overview:
AXI4-Lite write initiator between the LSU store path and the data-side bus. It is the counterpart of the AXI-Lite write responders (UART, SRAM).
- Accepts one store request at a time and performs byte-lane alignment.
- Issues AW and W independently, collects B, and returns a single completion with error status to the LSU.
- Misaligned stores are rejected locally; no bus traffic is generated for them.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed at 32; the lane logic assumes 4 byte lanes)
TIMEOUT_CYCLES, 1024, B-wait limit in cycles; used only with the optional feature

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  store request valid
req_ready  out  1  high only in IDLE
req_addr  in  32  byte address
req_data  in  32  store data, right-aligned
req_size  in  2  0=byte, 1=half, 2=word, 3=illegal
resp_valid  out  1  completion valid
resp_ready  in  1  LSU accepts the completion
resp_code  out  2  0=OKAY, 2=SLVERR/misaligned, 3=DECERR/timeout
awaddr  out  32  write address
awvalid  out  1  address valid
awready  in  1  address ready
wdata  out  32  lane-aligned write data
wstrb  out  4  byte strobes
wvalid  out  1  data valid
wready  in  1  data ready
bresp  in  2  write response code
bvalid  in  1  response valid
bready  out  1  response ready

Behaviour:
- Reset values: awvalid, wvalid, bready and resp_valid are 0; resp_code is 0; awaddr, wdata and wstrb are 0; req_ready is 1. Reset takes effect asynchronously and aborts any in-flight transaction; no completion is produced for it.
- State machine: IDLE, BUS, WAIT_B, RESP.
- IDLE:
  - On req_valid & req_ready, register the request.
  - off = req_addr[1:0].
  - Misaligned when size=1 and off[0]=1, when size=2 and off!=0, or when size=3. A misaligned request goes to RESP with resp_code=2.
  - Otherwise go to BUS with awvalid=wvalid=1 from the next cycle.
  - awaddr = req_addr, unmodified.
  - wdata = req_data << (8*off).
  - wstrb = (size0:4'b0001, size1:4'b0011, size2:4'b1111) << off, truncated to 4 bits.
- BUS:
  - Track aw_done and w_done flags.
  - awvalid drops the cycle after awvalid & awready; wvalid drops the cycle after wvalid & wready.
  - The two handshakes may occur in either order or in the same cycle.
  - Once valid is asserted, awaddr, wdata and wstrb stay stable until the matching handshake completes. Valid never drops without a handshake.
  - When both flags are set (including the cycle in which the last handshake occurs), go to WAIT_B.
- WAIT_B:
  - bready=1.
  - On bvalid, capture bresp into resp_code (EXOKAY is mapped to 0) and go to RESP.
  - bready is never asserted outside WAIT_B.
- RESP:
  - resp_valid=1, held until resp_ready; resp_code is stable while held.
  - On the handshake, return to IDLE with req_ready=1 in the next cycle.
  - If resp_ready is already high on entry, the completion takes one cycle.
- Best-case latency, with the slave always ready and returning B one cycle after W: request accepted at cycle N; AW/W handshake at N+1; B at N+2; resp_valid at N+3. Misaligned: resp_valid at N+1.
- Only one transaction is outstanding at a time; no request is accepted outside IDLE.

Optional Feature:
YSYX_23060236_LSU_WMASTER_TIMEOUT_EN
- Defined: a counter clears on entry to BUS and increments every cycle in BUS or WAIT_B. When it reaches TIMEOUT_CYCLES-1 with no B handshake:
  - go to RESP with resp_code=3;
  - drop awvalid, wvalid and bready;
  - ignore any later bvalid.
  A B handshake in the same cycle as the timeout wins and uses the normal bresp.
- Undefined: no counter logic; the block waits indefinitely.

Decomposition:
- Package ysyx_23060236_axi_pkg holds:
  - the resp constants OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3;
  - the size encodings;
  - the state enum.
- Sub-module ysyx_23060236_store_align: combinational; maps (addr[1:0], size, data) to (wdata, wstrb, misaligned). The same sub-module is reused later by the read-side extract.

Test Plan:
- Byte store: addr 0xa00003f8, data 0x41, size 0, slave always ready -> wstrb=0001, wdata=0x00000041, AW/W handshake in the same cycle, resp_code=0 at N+3.
- Half store: addr 0x80000002, data 0xBEEF, size 1 -> wstrb=1100, wdata=0xBEEF0000. Slave takes AW 3 cycles before W -> awaddr held stable, single completion.
- Misaligned word at 0x80000001 -> no awvalid or wvalid at any point; resp_valid at N+1 with resp_code=2.
- Slave returns bresp=2 and the LSU holds resp_ready low for 4 cycles -> resp_valid and resp_code=2 stable throughout; req_ready=0 throughout.
- reset low during BUS with awvalid high -> awvalid, wvalid and bready are 0 immediately; req_ready=1; no resp_valid after release.
- With TIMEOUT_EN and TIMEOUT_CYCLES=8, bvalid never asserted -> resp_code=3 eight cycles after entry to BUS; a late bvalid is ignored and the next request completes normally.

Source files
------------

// File: rtl/ysyx_23060236_axi_pkg.sv
// Shared AXI4-Lite definitions for the LSU bus masters.
//   - AXI response codes (OKAY/EXOKAY/SLVERR/DECERR)
//   - LSU access size encodings
//   - write-master state enum
package ysyx_23060236_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_ILL  = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUS    = 2'd1,
        ST_WAIT_B = 2'd2,
        ST_RESP   = 2'd3
    } wm_state_e;

endpackage

// File: rtl/ysyx_23060236_lsu_wmaster_if.sv
// AXI4-Lite write channels (AW, W, B) between an initiator and a responder.
//   master modport: drives awaddr/awvalid, wdata/wstrb/wvalid, bready
//   slave  modport: drives awready, wready, bresp/bvalid
interface ysyx_23060236_lsu_wmaster_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_23060236_store_align.sv
// Byte-lane alignment for 32-bit stores (purely combinational).
//   off_i        : address bits [1:0]
//   size_i       : access size (byte/half/word/illegal)
//   data_i       : right-aligned store data
//   wdata_o      : data shifted onto its byte lanes
//   wstrb_o      : byte strobes for the access
//   misaligned_o : access crosses its natural boundary or size is illegal
module ysyx_23060236_store_align
    import ysyx_23060236_axi_pkg::*;
(
    input  logic [1:0]  off_i,
    input  size_e       size_i,
    input  logic [31:0] data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        misaligned_o
);
    logic [3:0] base_strb;

    always_comb begin
        base_strb    = '0;
        misaligned_o = 1'b0;
        unique case (size_i)
            SIZE_BYTE: base_strb = 4'b0001;
            SIZE_HALF: begin
                base_strb    = 4'b0011;
                misaligned_o = off_i[0];
            end
            SIZE_WORD: begin
                base_strb    = 4'b1111;
                misaligned_o = (off_i != 2'd0);
            end
            default: begin
                base_strb    = '0;
                misaligned_o = 1'b1;
            end
        endcase
        wstrb_o = base_strb << off_i;
        wdata_o = data_i << {off_i, 3'b000};
    end
endmodule

// File: rtl/ysyx_23060236_lsu_wmaster.sv
// AXI4-Lite write initiator for the LSU store path.
// One store at a time: aligns lanes, issues AW and W independently, waits
// for B and returns a single completion. Misaligned stores complete locally
// with SLVERR and never touch the bus.
//   clock, reset (async, active-low)
//   req_*  : LSU store request (valid/ready, addr, data, size)
//   resp_* : completion (valid/ready, code 0=OKAY 2=SLVERR 3=DECERR/timeout)
//   axi    : AXI4-Lite write channels (master modport)
// Optional: define YSYX_23060236_LSU_WMASTER_TIMEOUT_EN to abort a transaction
// with DECERR after TIMEOUT_CYCLES cycles in BUS/WAIT_B.
module ysyx_23060236_lsu_wmaster
    import ysyx_23060236_axi_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_size,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [1:0]        resp_code,
    ysyx_23060236_lsu_wmaster_if.master axi
);
    wm_state_e         state_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [1:0]        resp_code_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              bready_q;
    logic              aw_done_q;
    logic              w_done_q;

    logic [31:0] al_wdata;
    logic [3:0]  al_wstrb;
    logic        al_mis;

    ysyx_23060236_store_align u_align (
        .off_i        (req_addr[1:0]),
        .size_i       (size_e'(req_size)),
        .data_i       (req_data),
        .wdata_o      (al_wdata),
        .wstrb_o      (al_wstrb),
        .misaligned_o (al_mis)
    );

    logic aw_hs, w_hs, b_hs, aw_done_d, w_done_d;
    assign aw_hs     = awvalid_q & axi.awready;
    assign w_hs      = wvalid_q & axi.wready;
    assign b_hs      = bready_q & axi.bvalid;
    // Done flags include the handshake of the current cycle so the move to
    // WAIT_B happens in the same cycle as the last handshake.
    assign aw_done_d = aw_done_q | aw_hs;
    assign w_done_d  = w_done_q | w_hs;

`ifdef YSYX_23060236_LSU_WMASTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             timeout;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_code_q  <= RESP_OKAY;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
`ifdef YSYX_23060236_LSU_WMASTER_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        if (al_mis) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_code_q  <= RESP_SLVERR;
                        end else begin
                            state_q   <= ST_BUS;
                            awaddr_q  <= req_addr;
                            wdata_q   <= al_wdata;
                            wstrb_q   <= al_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
`ifdef YSYX_23060236_LSU_WMASTER_TIMEOUT_EN
                            cnt_q     <= '0;
`endif
                        end
                    end
                end

                ST_BUS: begin
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    if (aw_hs) awvalid_q <= 1'b0;
                    if (w_hs)  wvalid_q  <= 1'b0;
`ifdef YSYX_23060236_LSU_WMASTER_TIMEOUT_EN
                    cnt_q <= cnt_q + 1'b1;
                    if (timeout) begin
                        state_q      <= ST_RESP;
                        awvalid_q    <= 1'b0;
                        wvalid_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_code_q  <= RESP_DECERR;
                    end else
`endif
                    if (aw_done_d && w_done_d) begin
                        state_q  <= ST_WAIT_B;
                        bready_q <= 1'b1;
                    end
                end

                ST_WAIT_B: begin
`ifdef YSYX_23060236_LSU_WMASTER_TIMEOUT_EN
                    cnt_q <= cnt_q + 1'b1;
`endif
                    // A B handshake takes priority over a coincident timeout.
                    if (b_hs) begin
                        state_q      <= ST_RESP;
                        bready_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_code_q  <= (axi.bresp == RESP_EXOKAY) ? RESP_OKAY : axi.bresp;
                    end
`ifdef YSYX_23060236_LSU_WMASTER_TIMEOUT_EN
                    else if (timeout) begin
                        state_q      <= ST_RESP;
                        bready_q     <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_code_q  <= RESP_DECERR;
                    end
`endif
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign resp_valid  = resp_valid_q;
    assign resp_code   = resp_code_q;
    assign axi.awaddr  = awaddr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
endmodule

// File: tb/tb_ysyx_23060236_lsu_wmaster.sv
// Directed self-checking bench for the LSU AXI4-Lite write master.
module tb_ysyx_23060236_lsu_wmaster;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_code;

    always #5 clock = ~clock;

    ysyx_23060236_lsu_wmaster_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ysyx_23060236_lsu_wmaster #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_size   (req_size),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_code  (resp_code),
        .axi        (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a request for one cycle; returns just after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        tick();
        req_valid = 1'b0;
    endtask

    // Always-ready slave, B returned one cycle after the AW/W handshake.
    task automatic fast_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] s, input logic [1:0] br,
                              input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                              input logic [1:0] exp_code);
        bus.awready = 1'b1;
        bus.wready  = 1'b1;
        resp_ready  = 1'b1;
        send(a, d, s);
        check({tag, "_awvalid"}, 32'(bus.awvalid), 32'd1);
        check({tag, "_wvalid"},  32'(bus.wvalid),  32'd1);
        check({tag, "_awaddr"},  bus.awaddr, a);
        check({tag, "_wdata"},   bus.wdata, exp_wdata);
        check({tag, "_wstrb"},   32'(bus.wstrb), 32'(exp_wstrb));
        check({tag, "_req_rdy"}, 32'(req_ready), 32'd0);
        tick();
        check({tag, "_awv_drop"}, 32'(bus.awvalid), 32'd0);
        check({tag, "_wv_drop"},  32'(bus.wvalid),  32'd0);
        check({tag, "_bready"},   32'(bus.bready),  32'd1);
        bus.bvalid = 1'b1;
        bus.bresp  = br;
        tick();
        bus.bvalid = 1'b0;
        check({tag, "_resp_v"},  32'(resp_valid), 32'd1);
        check({tag, "_code"},    32'(resp_code),  32'(exp_code));
        check({tag, "_brdy_lo"}, 32'(bus.bready), 32'd0);
        tick();
        check({tag, "_resp_done"}, 32'(resp_valid), 32'd0);
        check({tag, "_idle_rdy"},  32'(req_ready),  32'd1);
    endtask

    logic [31:0] mis_addr [3];
    logic [1:0]  mis_size [3];

    initial begin
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_data    = '0;
        req_size    = '0;
        resp_ready  = 1'b1;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'd0;

        // Reset state
        #12;
        check("rst_awvalid", 32'(bus.awvalid), 32'd0);
        check("rst_wvalid",  32'(bus.wvalid),  32'd0);
        check("rst_bready",  32'(bus.bready),  32'd0);
        check("rst_resp_v",  32'(resp_valid),  32'd0);
        check("rst_code",    32'(resp_code),   32'd0);
        check("rst_awaddr",  bus.awaddr,       32'd0);
        check("rst_wdata",   bus.wdata,        32'd0);
        check("rst_wstrb",   32'(bus.wstrb),   32'd0);
        check("rst_req_rdy", 32'(req_ready),   32'd1);
        @(negedge clock);
        reset = 1'b1;
        tick();

        // Byte store, slave always ready
        fast_store("byte", 32'ha00003f8, 32'h00000041, 2'd0, 2'd0, 32'h00000041, 4'b0001, 2'd0);

        // Half store at offset 2; AW accepted 3 cycles before W
        bus.awready = 1'b1;
        bus.wready  = 1'b0;
        resp_ready  = 1'b1;
        send(32'h80000002, 32'h0000beef, 2'd1);
        check("half_wstrb", 32'(bus.wstrb), 32'h0000000c);
        check("half_wdata", bus.wdata, 32'hbeef0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.awready = 1'b0;
            check("half_awv_lo", 32'(bus.awvalid), 32'd0);
            check("half_wv_hold", 32'(bus.wvalid), 32'd1);
            check("half_wdata_hold", bus.wdata, 32'hbeef0000);
            check("half_awaddr_hold", bus.awaddr, 32'h80000002);
            check("half_bready_lo", 32'(bus.bready), 32'd0);
        end
        bus.wready = 1'b1;
        tick();
        check("half_wv_drop", 32'(bus.wvalid), 32'd0);
        check("half_bready", 32'(bus.bready), 32'd1);
        bus.bvalid = 1'b1;
        bus.bresp  = 2'd0;
        tick();
        bus.bvalid = 1'b0;
        check("half_resp_v", 32'(resp_valid), 32'd1);
        check("half_code", 32'(resp_code), 32'd0);
        tick();
        check("half_resp_done", 32'(resp_valid), 32'd0);
        tick();
        check("half_single", 32'(resp_valid), 32'd0);

        // Misaligned / illegal requests complete locally in one cycle
        mis_addr[0] = 32'h80000001; mis_size[0] = 2'd2;
        mis_addr[1] = 32'h80000003; mis_size[1] = 2'd1;
        mis_addr[2] = 32'h80000000; mis_size[2] = 2'd3;
        for (int i = 0; i < 3; i++) begin
            resp_ready = 1'b1;
            send(mis_addr[i], 32'h12345678, mis_size[i]);
            check("mis_resp_v", 32'(resp_valid), 32'd1);
            check("mis_code", 32'(resp_code), 32'd2);
            check("mis_awvalid", 32'(bus.awvalid), 32'd0);
            check("mis_wvalid", 32'(bus.wvalid), 32'd0);
            tick();
            check("mis_done", 32'(resp_valid), 32'd0);
            check("mis_awvalid2", 32'(bus.awvalid), 32'd0);
            check("mis_req_rdy", 32'(req_ready), 32'd1);
        end

        // Word store: W before AW, bresp=SLVERR, LSU stalls the completion
        bus.awready = 1'b0;
        bus.wready  = 1'b1;
        resp_ready  = 1'b0;
        send(32'h80000010, 32'h12345678, 2'd2);
        check("word_wstrb", 32'(bus.wstrb), 32'h0000000f);
        check("word_wdata", bus.wdata, 32'h12345678);
        tick();
        check("word_wv_drop", 32'(bus.wvalid), 32'd0);
        check("word_awv_hold", 32'(bus.awvalid), 32'd1);
        check("word_awaddr", bus.awaddr, 32'h80000010);
        bus.awready = 1'b1;
        tick();
        check("word_bready", 32'(bus.bready), 32'd1);
        bus.bvalid = 1'b1;
        bus.bresp  = 2'd2;
        tick();
        bus.bvalid = 1'b0;
        bus.bresp  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            check("stall_resp_v", 32'(resp_valid), 32'd1);
            check("stall_code", 32'(resp_code), 32'd2);
            check("stall_req_rdy", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        check("stall_done", 32'(resp_valid), 32'd0);
        check("stall_req_rdy2", 32'(req_ready), 32'd1);

        // EXOKAY maps to OKAY; byte at offset 1
        fast_store("exok", 32'h80000021, 32'h000000a5, 2'd0, 2'd1, 32'h0000a500, 4'b0010, 2'd0);
        // DECERR passes through; half at offset 0
        fast_store("decerr", 32'h80000030, 32'h00001234, 2'd1, 2'd3, 32'h00001234, 4'b0011, 2'd3);

        // Asynchronous reset while in BUS
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        send(32'h80000040, 32'hcafef00d, 2'd2);
        check("ar_awvalid_pre", 32'(bus.awvalid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_awvalid", 32'(bus.awvalid), 32'd0);
        check("ar_wvalid", 32'(bus.wvalid), 32'd0);
        check("ar_bready", 32'(bus.bready), 32'd0);
        check("ar_req_rdy", 32'(req_ready), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ar_no_resp", 32'(resp_valid), 32'd0);
            check("ar_awv_idle", 32'(bus.awvalid), 32'd0);
        end

`ifdef YSYX_23060236_LSU_WMASTER_TIMEOUT_EN
        // Timeout after 8 cycles in BUS/WAIT_B with no B response
        bus.awready = 1'b1;
        bus.wready  = 1'b1;
        resp_ready  = 1'b0;
        send(32'h80000050, 32'h00000077, 2'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("to_wait", 32'(resp_valid), 32'd0);
        end
        tick();
        check("to_resp_v", 32'(resp_valid), 32'd1);
        check("to_code", 32'(resp_code), 32'd3);
        check("to_bready", 32'(bus.bready), 32'd0);
        check("to_awvalid", 32'(bus.awvalid), 32'd0);
        bus.bvalid = 1'b1;
        bus.bresp  = 2'd0;
        tick();
        check("to_late_b", 32'(resp_code), 32'd3);
        check("to_late_brdy", 32'(bus.bready), 32'd0);
        resp_ready = 1'b1;
        tick();
        bus.bvalid = 1'b0;
        check("to_done", 32'(resp_valid), 32'd0);
        fast_store("to_next", 32'h80000054, 32'h00000099, 2'd0, 2'd0, 32'h00000099, 4'b0001, 2'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
